// File: rtl/window_accumulator.sv
// window_accumulator: per-channel WIN-bit detection history with popcount and criterion handshake.
// Optional WINDOW_ACC_ADDR_CHECK_EN adds a sticky err_addr flag for out-of-range sample addresses.
module window_accumulator #(
  parameter int WIN   = 8,
  parameter int DEPTH = 600,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic [AW-1:0] sample_addr,
  input  logic          sample_bit,
  output logic          sample_ready,
  output logic          crit_start,
  output logic [AW-1:0] crit_addr,
  output logic [7:0]    crit_sum,
  input  logic          crit_done,
  output logic          busy
`ifdef WINDOW_ACC_ADDR_CHECK_EN
  , output logic        err_addr
`endif
);
  typedef enum logic [2:0] {S_CLR, S_IDLE, S_RD, S_CALC, S_WR, S_WAIT} state_t;
  state_t r_state, w_next;
  logic [WIN-1:0] r_mem [DEPTH];
  logic [WIN-1:0] r_rdata, r_new, w_new;
  logic [AW-1:0]  r_clr, r_addr;
  logic [7:0]     r_sum, w_sum;
  logic           r_bit, w_acc, w_bad;
  assign sample_ready = r_state == S_IDLE;
  assign busy         = r_state != S_IDLE;
  assign w_acc        = sample_valid && sample_ready;
`ifdef WINDOW_ACC_ADDR_CHECK_EN
  assign w_bad = {1'b0, sample_addr} >= (AW+1)'(DEPTH);
`else
  assign w_bad = 1'b0;
`endif
  // Truncating the concatenation drops the oldest bit of the history.
  assign w_new = WIN'({r_rdata, r_bit});
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < WIN; i++) w_sum = w_sum + 8'(w_new[i]);
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLR:   w_next = (r_clr == AW'(DEPTH - 1)) ? S_IDLE : S_CLR;
      S_IDLE:  w_next = (w_acc && !w_bad) ? S_RD : S_IDLE;
      S_RD:    w_next = S_CALC;
      S_CALC:  w_next = S_WR;
      S_WR:    w_next = S_WAIT;
      S_WAIT:  w_next = crit_done ? S_IDLE : S_WAIT;
      default: w_next = S_CLR;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_CLR;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr      <= '0;
      r_addr     <= '0;
      r_bit      <= 1'b0;
      r_new      <= '0;
      r_sum      <= '0;
      crit_start <= 1'b0;
      crit_addr  <= '0;
      crit_sum   <= '0;
    end else begin
      if (r_state == S_CLR) r_clr <= r_clr + 1'b1;
      if (w_acc && !w_bad) begin
        r_addr <= sample_addr;
        r_bit  <= sample_bit;
      end
      if (r_state == S_CALC) begin
        r_new <= w_new;
        r_sum <= w_sum;
      end
      crit_start <= r_state == S_WR;
      if (r_state == S_WR) begin
        crit_addr <= r_addr;
        crit_sum  <= r_sum;
      end
    end
  end
`ifdef WINDOW_ACC_ADDR_CHECK_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) err_addr <= 1'b0;
    else if (w_acc && w_bad) err_addr <= 1'b1;
`endif
  // History storage has no reset; the CLR sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (r_state == S_CLR) r_mem[r_clr] <= '0;
    else if (r_state == S_WR) r_mem[r_addr] <= r_new;
    if (r_state == S_RD) r_rdata <= r_mem[r_addr];
  end
endmodule

// File: tb/tb_window_accumulator.sv
// tb_window_accumulator: randomized self-checking bench for window_accumulator.
module tb_window_accumulator;
  localparam int WIN = 8, DEPTH = 600, AW = 10;
  logic clk = 1'b0, reset = 1'b1;
  logic sample_valid = 1'b0, sample_bit = 1'b0, crit_done = 1'b0;
  logic [AW-1:0] sample_addr = '0;
  logic sample_ready, crit_start, busy;
  logic [AW-1:0] crit_addr;
  logic [7:0] crit_sum;
`ifdef WINDOW_ACC_ADDR_CHECK_EN
  logic err_addr;
`endif
  int errs = 0, checks = 0;
  int hv [DEPTH];
  window_accumulator #(.WIN(WIN), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_addr(sample_addr),
    .sample_bit(sample_bit), .sample_ready(sample_ready), .crit_start(crit_start),
    .crit_addr(crit_addr), .crit_sum(crit_sum), .crit_done(crit_done), .busy(busy)
`ifdef WINDOW_ACC_ADDR_CHECK_EN
    , .err_addr(err_addr)
`endif
  );
  always #5 clk = ~clk;
  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) hv[i] = 0;
  endfunction
  // Reference: history kept as an integer, shifted arithmetically, window taken modulo 2**WIN.
  function automatic int model_step(input int ch, input int b);
    hv[ch] = (hv[ch] * 2 + b) % (1 << WIN);
    return $countones(hv[ch]);
  endfunction
  task automatic send(input int ch, input int b, input int dly, output int lat,
                      output logic [AW-1:0] a, output logic [7:0] s, output int extra,
                      output bit stable, output bit rdy_low, output logic rdy_after);
    int n = 0;
    @(negedge clk);
    while (!sample_ready && n < 2000) begin @(negedge clk); n++; end
    sample_valid = 1'b1; sample_addr = AW'(ch); sample_bit = b[0];
    @(posedge clk); #1;
    sample_valid = 1'b0;
    lat = 0;
    while (!crit_start && lat < 20) begin @(posedge clk); #1; lat++; end
    a = crit_addr; s = crit_sum; extra = 0; stable = 1'b1; rdy_low = 1'b1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (i > 0 && crit_start) extra++;
      if (crit_addr !== a || crit_sum !== s) stable = 1'b0;
      if (sample_ready) rdy_low = 1'b0;
    end
    crit_done = 1'b1;
    @(posedge clk); #1;
    rdy_after = sample_ready;
    @(negedge clk);
    crit_done = 1'b0;
  endtask
  task automatic test_reset();
    int cnt = 0;
    reset = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sample_ready !== 1'b0 || crit_start !== 1'b0 || crit_addr !== '0 || crit_sum !== '0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL reset_values: got ready=%b start=%b addr=%0d sum=%0d busy=%b expected 0 0 0 0 1",
               sample_ready, crit_start, crit_addr, crit_sum, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    while (!sample_ready && cnt < 2000) begin @(posedge clk); #1; cnt++; end
    checks++;
    if (cnt != DEPTH) begin errs++; $display("FAIL clr_length: got %0d expected %0d", cnt, DEPTH); end
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask
  task automatic test_cleared();
    int lat, ex, e; logic [AW-1:0] a; logic [7:0] s; bit st, rl; logic ra;
    for (int i = 0; i < 3; i++) begin
      int ch = $urandom_range(10, 500);
      e = model_step(ch, 0);
      send(ch, 0, 2, lat, a, s, ex, st, rl, ra);
      checks++;
      if (s !== 8'(e) || a !== AW'(ch)) begin
        errs++; $display("FAIL cleared_ch%0d: got addr=%0d sum=%0d expected addr=%0d sum=%0d", ch, a, s, ch, e);
      end
    end
  endtask
  task automatic test_single();
    int lat, ex, e; logic [AW-1:0] a; logic [7:0] s; bit st, rl; logic ra;
    e = model_step(5, 1);
    send(5, 1, 3, lat, a, s, ex, st, rl, ra);
    checks++;
    if (lat != 3) begin errs++; $display("FAIL single_latency: got %0d expected 3", lat); end
    checks++;
    if (a !== AW'(5) || s !== 8'(e)) begin errs++; $display("FAIL single_out: got addr=%0d sum=%0d expected 5 %0d", a, s, e); end
    checks++;
    if (ra !== 1'b1 || ex != 0) begin errs++; $display("FAIL single_ready: got ready=%b repulses=%0d expected 1 0", ra, ex); end
  endtask
  task automatic test_saturate();
    int lat, ex, e; logic [AW-1:0] a; logic [7:0] s; bit st, rl; logic ra;
    int seq [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7};
    for (int i = 0; i < 10; i++) begin
      int b = (i < 9) ? 1 : 0;
      e = model_step(599, b);
      send(599, b, 1, lat, a, s, ex, st, rl, ra);
      checks++;
      if (s !== 8'(e) || s !== 8'(seq[i]) || a !== AW'(599)) begin
        errs++; $display("FAIL saturate_%0d: got addr=%0d sum=%0d expected 599 %0d", i, a, s, seq[i]);
      end
    end
  endtask
  task automatic test_interleave();
    int lat, ex, e; logic [AW-1:0] a; logic [7:0] s; bit st, rl; logic ra;
    for (int i = 0; i < 6; i++) begin
      int ch = i % 2;
      int b = (ch == 0) ? 1 : 0;
      e = model_step(ch, b);
      send(ch, b, 2, lat, a, s, ex, st, rl, ra);
      checks++;
      if (s !== 8'(e) || a !== AW'(ch)) begin
        errs++; $display("FAIL interleave_%0d: got addr=%0d sum=%0d expected %0d %0d", i, a, s, ch, e);
      end
    end
  endtask
  task automatic test_hold();
    int lat, ex, e; logic [AW-1:0] a; logic [7:0] s; bit st, rl; logic ra;
    e = model_step(7, 1);
    send(7, 1, 50, lat, a, s, ex, st, rl, ra);
    checks++;
    if (!st || ex != 0 || !rl) begin errs++; $display("FAIL hold_wait: got stable=%b repulses=%0d ready_low=%b expected 1 0 1", st, ex, rl); end
    checks++;
    if (s !== 8'(e) || ra !== 1'b1) begin errs++; $display("FAIL hold_out: got sum=%0d ready=%b expected %0d 1", s, ra, e); end
    @(negedge clk); crit_done = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sample_ready !== 1'b1 || busy !== 1'b0 || crit_start !== 1'b0) begin
      errs++; $display("FAIL idle_done: got ready=%b busy=%b start=%b expected 1 0 0", sample_ready, busy, crit_start);
    end
    @(negedge clk); crit_done = 1'b0;
  endtask
  task automatic test_random();
    int lat, ex, e; logic [AW-1:0] a; logic [7:0] s; bit st, rl; logic ra;
    for (int i = 0; i < 25; i++) begin
      int ch = $urandom_range(2, 6);
      int b = $urandom_range(0, 1);
      e = model_step(ch, b);
      send(ch, b, $urandom_range(1, 6), lat, a, s, ex, st, rl, ra);
      checks++;
      if (lat != 3 || a !== AW'(ch) || s !== 8'(e) || ra !== 1'b1) begin
        errs++; $display("FAIL random_%0d: got lat=%0d addr=%0d sum=%0d ready=%b expected 3 %0d %0d 1", i, lat, a, s, ra, ch, e);
      end
    end
  endtask
  task automatic test_back_to_back();
    int lat, ex, e; logic [AW-1:0] a; logic [7:0] s; bit st, rl; logic ra;
    int bits [3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      e = model_step(42, bits[i]);
      send(42, bits[i], 1, lat, a, s, ex, st, rl, ra);
      checks++;
      if (s !== 8'(e) || lat != 3) begin errs++; $display("FAIL b2b_%0d: got sum=%0d lat=%0d expected %0d 3", i, s, lat, e); end
    end
  endtask
  task automatic test_reset_wait();
    int cnt = 0, lat, ex, e; logic [AW-1:0] a; logic [7:0] s; bit st, rl; logic ra;
    @(negedge clk);
    sample_valid = 1'b1; sample_addr = AW'(5); sample_bit = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || crit_start !== 1'b0 || crit_addr !== AW'(5)) begin
      errs++; $display("FAIL wait_state: got busy=%b start=%b addr=%0d expected 1 0 5", busy, crit_start, crit_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (sample_ready !== 1'b0 || crit_start !== 1'b0 || crit_addr !== '0 || crit_sum !== '0 || busy !== 1'b1) begin
      errs++; $display("FAIL reset_async: got ready=%b start=%b addr=%0d sum=%0d busy=%b expected 0 0 0 0 1",
                       sample_ready, crit_start, crit_addr, crit_sum, busy);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    while (!sample_ready && cnt < 2000) begin @(posedge clk); #1; cnt++; end
    checks++;
    if (cnt != DEPTH) begin errs++; $display("FAIL reclr_length: got %0d expected %0d", cnt, DEPTH); end
    e = model_step(5, 0);
    send(5, 0, 2, lat, a, s, ex, st, rl, ra);
    checks++;
    if (s !== 8'(e)) begin errs++; $display("FAIL reclr_ch5: got sum=%0d expected %0d", s, e); end
    e = model_step(599, 1);
    send(599, 1, 2, lat, a, s, ex, st, rl, ra);
    checks++;
    if (s !== 8'(e)) begin errs++; $display("FAIL reclr_ch599: got sum=%0d expected %0d", s, e); end
  endtask
`ifdef WINDOW_ACC_ADDR_CHECK_EN
  task automatic test_addr_check();
    int starts = 0;
    @(negedge clk);
    checks++;
    if (err_addr !== 1'b0) begin errs++; $display("FAIL err_initial: got %b expected 0", err_addr); end
    sample_valid = 1'b1; sample_addr = AW'(700); sample_bit = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (crit_start) starts++; end
    checks++;
    if (err_addr !== 1'b1 || sample_ready !== 1'b1 || starts != 0) begin
      errs++; $display("FAIL err_addr: got err=%b ready=%b starts=%0d expected 1 1 0", err_addr, sample_ready, starts);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_cleared();
    test_single();
    test_saturate();
    test_interleave();
    test_hold();
    test_random();
    test_back_to_back();
    test_reset_wait();
`ifdef WINDOW_ACC_ADDR_CHECK_EN
    test_addr_check();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/window_accumulator.md
Name: window_accumulator

Overview:
- Upstream stage of the per-channel threshold criterion block.
- Accepts one detection bit per channel sample and keeps a per-channel shift history of the last WIN bits in internal storage.
- Produces the channel's hit count (`crit_sum`) with its channel address, then runs a start/done handshake with the downstream criterion stage.
- Processes one sample at a time; upstream is back-pressured through `sample_ready`.

Parameters:
- WIN, 8, history window length in samples; legal range 2..8.
- DEPTH, 600, number of channels (history entries).
- AW, 10, channel address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample_valid  input  1  upstream sample present.
- sample_addr  input  AW  channel of the sample.
- sample_bit  input  1  detection bit for this sample.
- sample_ready  output  1  block can accept a sample this cycle.
- crit_start  output  1  one-cycle request to the criterion stage.
- crit_addr  output  AW  channel address presented to the criterion stage.
- crit_sum  output  8  popcount of the updated history, zero-extended to 8 bits.
- crit_done  input  1  criterion stage finished the current request.
- busy  output  1  high in every state except IDLE.
- err_addr  output  1  sticky out-of-range flag; exists only with the optional feature.

Behaviour:
- Reset values: `sample_ready`=0, `crit_start`=0, `crit_addr`=0, `crit_sum`=0, `busy`=1, `err_addr`=0. State goes to CLR and the clear counter goes to 0.
- Reset asserted mid-operation: abort immediately and return to CLR. Any outstanding criterion request is abandoned and all history is cleared again.
- CLR state:
  - Writes an all-zero history to address clear counter, incrementing once per cycle.
  - After address DEPTH-1 is written, the next state is IDLE. CLR lasts exactly DEPTH cycles.
  - `sample_ready`=0 throughout.
- IDLE state:
  - `sample_ready`=1.
  - On `sample_valid` && `sample_ready`: capture `sample_addr` and `sample_bit`, then go to RD. `sample_ready` drops in the following cycle.
- RD state: issue a synchronous read of the captured address; data is available in the next cycle. Go to CALC.
- CALC state:
  - new_hist = {hist[WIN-2:0], sample_bit}; the oldest bit is discarded.
  - sum = count of ones in new_hist, range 0..WIN.
  - Go to WR.
- WR state:
  - Write new_hist back to the captured address.
  - Register `crit_addr` = captured address and `crit_sum` = sum.
  - Assert `crit_start` for exactly one cycle, in the cycle after WR.
  - Go to WAIT.
- WAIT state:
  - `crit_addr` and `crit_sum` are held stable until `crit_done` is sampled high.
  - On `crit_done`, go to IDLE; `sample_ready` is high on the next cycle.
  - `crit_done` observed in any state other than WAIT is ignored.
- Latency: handshake accepted at edge T → `crit_start` high in cycle T+3. Minimum sample spacing is 5 cycles plus the criterion latency.
- Same channel sampled back-to-back: the second sample reads the history written by the first. WR completes before IDLE is re-entered, so there is no hazard.
- `crit_sum` never exceeds WIN; bits [7:4] are always 0.

Optional Feature:
- Macro: WINDOW_ACC_ADDR_CHECK_EN.
- With the macro defined:
  - In IDLE, a handshake with `sample_addr` >= DEPTH is consumed without any RAM access or criterion request.
  - `err_addr` is set to 1 and stays set until reset.
  - The state remains IDLE and `sample_ready` stays 1.
- Without the macro: no address check is made, the `err_addr` port is absent, and out-of-range addresses are undefined usage.

Test Plan:
- Reset, then count cycles → `sample_ready` rises exactly DEPTH (600) cycles after reset deassertion; reading any channel afterwards gives `crit_sum`=0.
- Sample ch 5 with bit=1 and a downstream model that returns `crit_done` 3 cycles after start → `crit_start` at T+3, `crit_addr`=5, `crit_sum`=1, `sample_ready` high again the cycle after `crit_done`.
- Ten samples on ch 599 with bits 1,1,1,1,1,1,1,1,1,0 and WIN=8 → `crit_sum` sequence 1,2,3,4,5,6,7,8,8,7 (saturates at the window size, then the 0 enters).
- Alternate samples on ch 0 and ch 1 → histories stay independent: ch 0 all ones gives `crit_sum` 1,2,3; ch 1 all zeros gives 0,0,0.
- Hold `crit_done` low for 50 cycles → `crit_addr`/`crit_sum` stable, `sample_ready`=0, `crit_start` never re-pulses. Pulse `crit_done` in IDLE → no effect.
- Assert reset during WAIT → outputs return to reset values and the 600-cycle clear runs again. With WINDOW_ACC_ADDR_CHECK_EN, `sample_addr`=700 → `err_addr`=1 and no `crit_start`.
